// File: rtl/risc_sequencer.sv
// risc_sequencer: multi-cycle fetch/decode/execute controller for the A/B/C + ALU datapath.
// Latency: LOAD/ADD 3 cycles, NOP 2, READOUT 3 (zero-wait ack, consumer ready); HALT/illegal stop in DECODE.
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; OUT_WAIT holds out_valid until out_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               run request, sampled only in IDLE or HALT (restarts at pc=0)
//   imem_req/addr/ack/rdata  instruction fetch handshake; rdata used only with ack
//   opcode_out, exec_en one-cycle execute strobe with the opcode (opcode is zero otherwise)
//   imm_out             immediate field of the instruction register, always visible
//   out_valid/out_ready READOUT handshake
//   pc, busy, halted, illegal, retired  status
module risc_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [5:0]         opcode_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic               exec_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [15:0]        retired
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  localparam logic [5:0] OP_NOP     = 6'b000000;
  localparam logic [5:0] OP_LOADA   = 6'b000001;
  localparam logic [5:0] OP_LOADB   = 6'b000010;
  localparam logic [5:0] OP_ADD     = 6'b000011;
  localparam logic [5:0] OP_READOUT = 6'b000100;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [15:0]       RET_ONE = 16'd1;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_illegal;
  logic [15:0]         r_retired;

  logic [5:0]          w_opcode;
  logic                w_pc_clr;
  logic                w_pc_inc;   // also retires the current instruction
  logic                w_ir_load;
  logic                w_ill_set;
  logic                w_ill_clr;

  // Bits between the immediate and the opcode carry no meaning.
  logic                w_unused_ir;

  assign w_opcode    = r_ir[INSTR_W-1 -: 6];
  assign w_unused_ir = ^r_ir;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, datapath controls and Moore outputs
  always_comb begin
    w_next_state = r_state;
    w_pc_clr     = 1'b0;
    w_pc_inc     = 1'b0;
    w_ir_load    = 1'b0;
    w_ill_set    = 1'b0;
    w_ill_clr    = 1'b0;
    imem_req     = 1'b0;
    exec_en      = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_clr     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_load    = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        case (w_opcode)
          OP_LOADA, OP_LOADB, OP_ADD: w_next_state = S_EXEC;
          OP_READOUT:                 w_next_state = S_OUT_WAIT;
          OP_NOP: begin
            w_pc_inc     = 1'b1;
            w_next_state = S_FETCH;
          end
          // HALT leaves pc pointing at the HALT word itself.
          OP_HALT:                    w_next_state = S_HALT;
          default: begin
            w_ill_set    = 1'b1;
            w_next_state = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        busy         = 1'b1;
        exec_en      = 1'b1;
        w_pc_inc     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_OUT_WAIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_pc_inc     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          w_pc_clr     = 1'b1;
          w_ill_clr    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath registers; retired is cleared only by rst, never by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_pc_clr) begin
        r_pc <= '0;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + PC_ONE;
      end
      if (w_pc_inc) begin
        r_retired <= r_retired + RET_ONE;
      end
      if (w_ir_load) begin
        r_ir <= imem_rdata;
      end
      if (w_ill_set) begin
        r_illegal <= 1'b1;
      end else if (w_ill_clr) begin
        r_illegal <= 1'b0;
      end
    end
  end

  // The decoder must only see a real opcode during the execute strobe.
  assign opcode_out = exec_en ? w_opcode : 6'b000000;
  assign imm_out    = r_ir[DATA_W-1:0];
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_risc_sequencer.sv
module tb_risc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, imem_req, imem_ack, exec_en, out_valid, out_ready;
  logic        busy, halted, illegal;
  logic [7:0]  imem_addr, imm_out, pc;
  logic [15:0] imem_rdata, retired;
  logic [5:0]  opcode_out;

  // Narrow-pc instance: ack tied to req, memory reads all NOPs.
  logic        start1, imem_req1, imem_ack1, exec_en1, out_valid1, out_ready1;
  logic        busy1, halted1, illegal1;
  logic [1:0]  imem_addr1, pc1;
  logic [15:0] rdata1, retired1;
  logic [5:0]  opcode_out1;
  logic [7:0]  imm_out1;
  assign imem_ack1 = imem_req1;
  assign rdata1    = 16'h0000;

  risc_sequencer #(.ADDR_W(8), .INSTR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode_out(opcode_out), .imm_out(imm_out), .exec_en(exec_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
  );

  risc_sequencer #(.ADDR_W(2), .INSTR_W(16), .DATA_W(8)) dut_narrow (
    .clk(clk), .rst(rst), .start(start1),
    .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_ack(imem_ack1), .imem_rdata(rdata1),
    .opcode_out(opcode_out1), .imm_out(imm_out1), .exec_en(exec_en1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .pc(pc1), .busy(busy1), .halted(halted1), .illegal(illegal1), .retired(retired1)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mem [256];
  int dly_min, dly_max, rlo_min, rlo_max;
  bit fetch_pend, rd_pend, prev_exec;
  int ack_cnt, rlo_cnt, busy_cnt, ov_cnt, req_len, req_min, req_max;
  logic [7:0]  req_addr, ov_pc;
  logic [31:0] obs_exec[$], exp_exec[$];
  logic [7:0]  obs_rd[$], exp_rd[$], obs_fetch[$], exp_fetch[$];

  // Reference machine state (instruction-level)
  logic [15:0] m_ret;
  logic [7:0]  m_pc;
  bit          m_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_run();
    obs_exec.delete(); exp_exec.delete(); obs_rd.delete(); exp_rd.delete();
    obs_fetch.delete(); exp_fetch.delete();
    fetch_pend = 0; rd_pend = 0; prev_exec = 0;
    busy_cnt = 0; ov_cnt = 0; req_min = 1000000; req_max = 0;
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) mem[a] = {6'h3F, 10'($urandom)};
  endtask

  // Walk the program one instruction at a time from address 0.
  task automatic model_run();
    logic [7:0]  p;
    logic [15:0] w;
    logic [5:0]  op;
    p = 8'd0;
    m_ill = 0;
    for (int n = 0; n < 2000; n++) begin
      w  = mem[p];
      op = w[15:10];
      exp_fetch.push_back(p);
      if (op == 6'h3F) break;
      if (op inside {6'd1, 6'd2, 6'd3}) exp_exec.push_back({10'h0, op, w[7:0], p});
      else if (op == 6'd4) exp_rd.push_back(p);
      else if (op != 6'd0) begin
        m_ill = 1;
        break;
      end
      p     = p + 8'd1;
      m_ret = m_ret + 16'd1;
    end
    m_pc = p;
  endtask

  // Drive one cycle of memory / consumer responses, observe, then advance one edge.
  task automatic step();
    if (imem_req) begin
      if (!fetch_pend) begin
        fetch_pend = 1; ack_cnt = $urandom_range(dly_max, dly_min);
        req_len = 0; req_addr = imem_addr;
      end
      req_len++;
      check("req_addr_stable", imem_addr, req_addr);
      check("addr_eq_pc", imem_addr, pc);
      if (ack_cnt == 0) begin
        imem_ack = 1'b1; imem_rdata = mem[imem_addr]; fetch_pend = 0;
        obs_fetch.push_back(imem_addr);
        if (req_len < req_min) req_min = req_len;
        if (req_len > req_max) req_max = req_len;
      end else begin
        imem_ack = 1'b0; imem_rdata = 16'($urandom); ack_cnt--;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
    end

    if (out_valid) begin
      if (!rd_pend) begin
        rd_pend = 1; rlo_cnt = $urandom_range(rlo_max, rlo_min); ov_pc = pc;
      end
      check("outwait_pc_hold", pc, ov_pc);
      ov_cnt++;
      out_ready = (rlo_cnt == 0);
      if (rlo_cnt == 0) begin
        rd_pend = 0; obs_rd.push_back(pc);
      end else rlo_cnt--;
    end else begin
      out_ready = 1'($urandom);
    end

    if (exec_en) begin
      obs_exec.push_back({10'h0, opcode_out, imm_out, pc});
      check("exec_one_cycle", prev_exec, 0);
    end else begin
      check("opcode_zero_idle", opcode_out, 0);
    end
    prev_exec = exec_en;
    check("busy_halt_excl", busy & halted, 0);
    if (busy) busy_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic run_prog(input int budget);
    clear_run();
    model_run();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < budget && !halted; c++) step();
    check("halted_in_time", halted, 1);
    check("final_pc", pc, m_pc);
    check("final_retired", retired, m_ret);
    check("final_illegal", illegal, m_ill);
    check("n_exec", obs_exec.size(), exp_exec.size());
    for (int i = 0; i < obs_exec.size() && i < exp_exec.size(); i++)
      check("exec_event", obs_exec[i], exp_exec[i]);
    check("n_readout", obs_rd.size(), exp_rd.size());
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++)
      check("readout_pc", obs_rd[i], exp_rd[i]);
    check("n_fetch", obs_fetch.size(), exp_fetch.size());
    for (int i = 0; i < obs_fetch.size() && i < exp_fetch.size(); i++)
      check("fetch_addr", obs_fetch[i], exp_fetch[i]);
  endtask

  // Entered at posedge+1: reset asserted and checked well away from any edge.
  task automatic async_reset_check();
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", {imem_req, exec_en, out_valid, busy, halted, illegal, opcode_out}, 0);
    check("arst_data", {imem_addr, imm_out, pc}, 0);
    check("arst_retired", retired, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_idle", {busy, halted, imem_req, out_valid}, 0);
    fetch_pend = 0; rd_pend = 0; prev_exec = 0; m_ret = 16'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; out_ready = 1'b0;
    start1 = 1'b0; out_ready1 = 1'b0;
    dly_min = 0; dly_max = 0; rlo_min = 0; rlo_max = 0;
    m_ret = 16'd0;
    #1;
    check("rst_ctrl", {imem_req, exec_en, out_valid, busy, halted, illegal, opcode_out}, 0);
    check("rst_data", {imem_addr, imm_out, pc}, 0);
    check("rst_retired", retired, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: LOADA 5, LOADB 3, ADD, HALT with zero-wait ack
    fill_halt();
    mem[0] = 16'h0405; mem[1] = 16'h0803; mem[2] = 16'h0C00; mem[3] = 16'hFC00;
    run_prog(200);
    check("t1_pc", pc, 3);
    check("t1_retired", retired, 3);
    check("t1_busy_cycles", busy_cnt, 11);

    // 2: ack delayed 4 cycles on every fetch
    fill_halt();
    mem[0] = 16'h0411;
    dly_min = 4; dly_max = 4;
    run_prog(200);
    check("t2_req_len_min", req_min, 5);
    check("t2_req_len_max", req_max, 5);
    check("t2_busy_cycles", busy_cnt, 13);
    dly_min = 0; dly_max = 0;

    // 3: READOUT with consumer stalled 6 cycles
    fill_halt();
    mem[0] = 16'h1077;
    rlo_min = 6; rlo_max = 6;
    run_prog(200);
    check("t3_valid_cycles", ov_cnt, 7);
    check("t3_pc", pc, 1);
    rlo_min = 0; rlo_max = 0;

    // 4: undefined opcode at pc=2, then restart
    fill_halt();
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'hA8C3;
    run_prog(200);
    check("t4_illegal", illegal, 1);
    check("t4_pc", pc, 2);
    check("t4_no_exec", obs_exec.size(), 0);
    start = 1'b1; step(); start = 1'b0;
    check("t4_illegal_clr", illegal, 0);
    check("t4_refetch", {imem_req, imem_addr}, {1'b1, 8'd0});
    async_reset_check();

    // 5: two-bit pc wraps over a NOP stream
    begin
      logic [1:0] seq[$];
      int nf;
      nf = 0;
      start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
      for (int c = 0; c < 40 && nf < 5; c++) begin
        if (imem_req1) begin
          seq.push_back(imem_addr1);
          if (nf == 4) check("t5_retired_at_wrap", retired1, 4);
          nf++;
        end
        @(posedge clk); #1;
      end
      check("t5_fetch_count", nf, 5);
      for (int i = 0; i < seq.size(); i++) check("t5_pc_seq", seq[i], i % 4);
      check("t5_no_error", {illegal1, halted1}, 0);
    end

    // Random programs with random ack delay and consumer stalls
    for (int t = 0; t < 25; t++) begin
      int len, k;
      logic [5:0] op;
      fill_halt();
      len = $urandom_range(14, 1);
      for (int a = 0; a < len; a++) begin
        k = $urandom_range(19, 0);
        if (k < 4)       op = 6'd1;
        else if (k < 8)  op = 6'd2;
        else if (k < 11) op = 6'd3;
        else if (k < 14) op = 6'd4;
        else if (k == 17) op = 6'($urandom_range(62, 5));
        else             op = 6'd0;
        mem[a] = {op, 2'($urandom), 8'($urandom)};
      end
      dly_min = 0; dly_max = $urandom_range(3, 0);
      rlo_min = 0; rlo_max = $urandom_range(4, 0);
      run_prog(3000);
    end
    dly_min = 0; dly_max = 0; rlo_min = 0; rlo_max = 0;

    // 6a: reset while waiting on the output handshake
    clear_run();
    fill_halt();
    mem[0] = 16'h1000;
    rlo_min = 1000; rlo_max = 1000;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) step();
    check("t6a_in_outwait", out_valid, 1);
    async_reset_check();
    rlo_min = 0; rlo_max = 0;
    fill_halt();
    mem[0] = 16'h0422;
    run_prog(200);

    // 6b: reset while a fetch is outstanding
    clear_run();
    dly_min = 1000; dly_max = 1000;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("t6b_fetch_pending", {imem_req, imem_ack}, {1'b1, 1'b0});
    async_reset_check();
    dly_min = 0; dly_max = 0;
    fill_halt();
    mem[0] = 16'h0C00; mem[1] = 16'h1001;
    run_prog(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
